// File: rtl/fetch_queue.sv
// fetch_queue: PC owner and instruction fetch FIFO between imem and decode.
// Redirects flush the queue and reload the PC; there is no bypass from imem to decode.
module fetch_queue #(
    parameter int          DWIDTH   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [31:0]               imem_addr,
    input  logic [DWIDTH-1:0]         imem_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DWIDTH-1:0]         out_instr,
    output logic [31:0]               out_pc,
    input  logic                      redirect,
    input  logic [31:0]               redirect_pc,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]        pc_q, pc_d;
    logic [AW-1:0]      rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DWIDTH+31:0] mem_q [DEPTH];
    logic               pop, push;

    assign pop       = (cnt_q != '0) & out_ready;
    assign push      = !redirect & ((cnt_q < CW'(DEPTH)) | pop);
    assign imem_addr = {2'b00, pc_q[31:2]};
    assign out_valid = cnt_q != '0;
    assign count     = cnt_q;
    // Head fields are forced to zero when empty since storage is never reset.
    assign out_pc    = out_valid ? mem_q[rd_q][DWIDTH+31:DWIDTH] : '0;
    assign out_instr = out_valid ? mem_q[rd_q][DWIDTH-1:0] : '0;

    always_comb begin
        pc_d  = redirect ? (redirect_pc & ~32'd3) : push ? pc_q + 32'd4 : pc_q;
        wr_d  = redirect ? '0 : push ? wr_q + AW'(1) : wr_q;
        rd_d  = redirect ? '0 : pop ? rd_q + AW'(1) : rd_q;
        cnt_d = redirect ? '0 : (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= {pc_q, imem_instr};
    end
endmodule
